click_counter_mc: RTL and testbench
===================================

// Module: click_counter_mc
// PURPOSE
//   Multi-channel debounced click counter; parametrised successor of the single-channel click counter.
//   Per channel: debounce a raw click input, emit a one-cycle pulse on each qualified rising edge,
//   and count the qualified clicks in a wrap or saturate counter with overflow flag and per-channel clear.
//   Sits between raw button/event inputs and status/readout logic.
// PARAMETERS
//   N_CH        4   number of independent click channels (>=1)
//   CNT_W       10  click counter width per channel (>=2)
//   DEB_CYCLES  4   consecutive identical samples needed to accept a level change (>=1)
//   WRAP        0   1: counter wraps to 0 and ovf pulses; 0: counter saturates and ovf is sticky
// PORTS
//   clk    in   1           system clock, all logic on rising edge
//   rst    in   1           asynchronous, active-low reset
//   click  in   N_CH        raw click level per channel
//   clr    in   N_CH        synchronous per-channel clear of count/ovf
//   y      out  N_CH        one-cycle pulse per accepted click
//   count  out  N_CH*CNT_W  packed counters, channel i at [i*CNT_W +: CNT_W]
//   ovf    out  N_CH        overflow: pulse (WRAP=1) or sticky saturation flag (WRAP=0)
// BEHAVIOUR
//   - Reset (rst=0, async): y=0, count=0, ovf=0, all channel FSMs in LOW, debounce counters 0.
//   - Per-channel FSM: LOW, DEB_HI, HIGH, DEB_LO. smp = click sample (synchronised if CLICK_SYNC_EN).
//     LOW: smp=1 -> DEB_HI with deb=1 (if DEB_CYCLES==1, go straight to HIGH and accept).
//     DEB_HI: smp=0 -> LOW; smp=1 and deb==DEB_CYCLES-1 -> HIGH and accept; else deb++.
//     HIGH: smp=0 -> DEB_LO with deb=1 (DEB_CYCLES==1: straight to LOW).
//     DEB_LO: smp=1 -> HIGH; smp=0 and deb==DEB_CYCLES-1 -> LOW; else deb++.
//   - Accept: registered y[i]=1 for exactly one cycle; count[i] += 1 on the same edge.
//     Latency: y high after DEB_CYCLES consecutive rising edges sampling smp=1 (no sync).
//     A glitch shorter than DEB_CYCLES samples produces no pulse and no count.
//   - Holding click high indefinitely yields exactly one pulse; the next pulse needs a debounced low first.
//   - Counter arithmetic, unsigned CNT_W bits:
//     WRAP=1: all-ones + 1 -> 0, ovf[i]=1 for that one cycle only.
//     WRAP=0: at all-ones count holds, ovf[i] set and held until clr[i] or reset; y still pulses.
//   - clr[i]=1: count[i]<=0 and ovf[i]<=0 next edge. Debounce FSM is NOT affected.
//     clr and accept on the same edge: clr wins (count=0, ovf=0) and y[i] still pulses.
//   - Channels fully independent; simultaneous accepts on several channels all count.
//   - Reset asserted mid-debounce discards partial debounce; deasserting reset with click held high
//     requires a full DEB_CYCLES qualification before the first pulse.
// CONFIGURATION
//   CLICK_SYNC_EN defined: 2-flop synchroniser per click bit ahead of the FSM, reset to 0;
//     adds exactly 2 cycles to pulse latency and to every debounce transition.
//   CLICK_SYNC_EN undefined: click sampled directly (caller guarantees synchronous input).
// STRUCTURE
//   Package click_pkg: ch_state_e enum {LOW, DEB_HI, HIGH, DEB_LO}; default constants
//     for N_CH, CNT_W, DEB_CYCLES; function clog2-based DEB_W = $clog2(DEB_CYCLES+1).
//   Sub-module click_channel (one instance per channel via generate): optional sync,
//     FSM, debounce counter, click counter, y/ovf regs. Top only slices/packs vectors.
// TESTING
//   1 Reset: rst=0 with random click/clr -> y=0, count=0, ovf=0 asynchronously and while held.
//   2 Clean click ch0, DEB_CYCLES=4: click=1 for 10 cycles -> one y[0] pulse 4 edges after rise,
//     count[0]=1; other channels unchanged.
//   3 Glitch: click[1]=1 for 3 cycles then 0 -> no y[1], count[1]=0; bounce 1,0,1 inside DEB_LO
//     after an accepted press -> no second pulse.
//   4 Saturate (WRAP=0, CNT_W=2): 5 accepted clicks -> count=3, ovf sticky 1 after 4th;
//     clr -> count=0, ovf=0. Wrap (WRAP=1): 4th click -> count=0, ovf one-cycle pulse.
//   5 clr[2] asserted on the accept edge -> y[2]=1, count[2]=0; simultaneous accepts on
//     all N_CH channels -> every count increments by 1.
//   6 CLICK_SYNC_EN build: repeat test 2 -> pulse 6 edges after rise; 1000-cycle random click
//     soak vs. behavioural model in both builds, zero mismatches.

Source files
------------

// File: rtl/click_pkg.sv
// Shared types and defaults for the multi-channel debounced click counter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package click_pkg;

   typedef enum logic [1:0] {
      LOW    = 2'd0,
      DEB_HI = 2'd1,
      HIGH   = 2'd2,
      DEB_LO = 2'd3
   } ch_state_e;

   localparam int N_CH_DEF       = 4;
   localparam int CNT_W_DEF      = 10;
   localparam int DEB_CYCLES_DEF = 4;

   // Width that holds 0..DEB_CYCLES; never narrower than one bit.
   function automatic int deb_w(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/click_channel.sv
// One click channel: optional 2-flop sync (CLICK_SYNC_EN), debounce FSM, wrap/saturate counter.
// Latency: y/count update DEB_CYCLES edges after a clean rise (+2 with CLICK_SYNC_EN).
// Backpressure: none; every accepted click is counted immediately.
module click_channel
   import click_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int WRAP       = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             click,
   input  logic             clr,
   output logic             y,
   output logic [CNT_W-1:0] count,
   output logic             ovf
);

   localparam int              DEB_W    = deb_w(DEB_CYCLES);
   localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
   localparam bit              WRAP_EN  = (WRAP != 0);

   logic smp;

`ifdef CLICK_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= '0;
      else      sync_q <= {sync_q[0], click};
   end

   assign smp = sync_q[1];
`else
   assign smp = click;
`endif

   ch_state_e        state_q, state_d;
   logic [DEB_W-1:0] deb_q, deb_d;
   logic             accept;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= LOW;
         deb_q   <= '0;
      end else begin
         state_q <= state_d;
         deb_q   <= deb_d;
      end
   end

   // deb counts consecutive samples that disagree with the settled level.
   always_comb begin
      state_d = state_q;
      deb_d   = deb_q;
      case (state_q)
         LOW: begin
            if (smp) begin
               if (DEB_CYCLES == 1) begin
                  state_d = HIGH;
               end else begin
                  state_d = DEB_HI;
                  deb_d   = DEB_ONE;
               end
            end
         end
         DEB_HI: begin
            if (!smp) begin
               state_d = LOW;
               deb_d   = '0;
            end else if (deb_q == DEB_LAST) begin
               state_d = HIGH;
               deb_d   = '0;
            end else begin
               deb_d = deb_q + DEB_ONE;
            end
         end
         HIGH: begin
            if (!smp) begin
               if (DEB_CYCLES == 1) begin
                  state_d = LOW;
               end else begin
                  state_d = DEB_LO;
                  deb_d   = DEB_ONE;
               end
            end
         end
         DEB_LO: begin
            if (smp) begin
               state_d = HIGH;
               deb_d   = '0;
            end else if (deb_q == DEB_LAST) begin
               state_d = LOW;
               deb_d   = '0;
            end else begin
               deb_d = deb_q + DEB_ONE;
            end
         end
         default: begin
            state_d = LOW;
            deb_d   = '0;
         end
      endcase
   end

   always_comb begin
      accept = 1'b0;
      case (state_q)
         LOW:     accept = smp && (DEB_CYCLES == 1);
         DEB_HI:  accept = smp && (deb_q == DEB_LAST);
         default: accept = 1'b0;
      endcase
   end

   // clr wins over a same-edge accept, but the pulse on y is still emitted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         y     <= 1'b0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         y <= accept;
         if (clr) begin
            count <= '0;
            ovf   <= 1'b0;
         end else if (accept) begin
            if (&count) begin
               ovf <= 1'b1;
               if (WRAP_EN) count <= '0;
            end else begin
               count <= count + CNT_W'(1);
               if (WRAP_EN) ovf <= 1'b0;
            end
         end else if (WRAP_EN) begin
            ovf <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/click_counter_mc.sv
// Multi-channel debounced click counter; N_CH independent click_channel slices (CLICK_SYNC_EN adds input sync).
// Latency: pulse/count DEB_CYCLES edges after a clean rise, +2 with CLICK_SYNC_EN.
// Backpressure: none; outputs are status registers, no handshake.
module click_counter_mc
   import click_pkg::*;
#(
   parameter int N_CH       = N_CH_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int WRAP       = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH-1:0]       click,
   input  logic [N_CH-1:0]       clr,
   output logic [N_CH-1:0]       y,
   output logic [N_CH*CNT_W-1:0] count,
   output logic [N_CH-1:0]       ovf
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      click_channel #(
         .CNT_W      (CNT_W),
         .DEB_CYCLES (DEB_CYCLES),
         .WRAP       (WRAP)
      ) u_ch (
         .clk   (clk),
         .rst   (rst),
         .click (click[i]),
         .clr   (clr[i]),
         .y     (y[i]),
         .count (count[i*CNT_W +: CNT_W]),
         .ovf   (ovf[i])
      );
   end

endmodule

// File: tb/tb_click_counter_mc.sv
// Directed checks plus a random soak for click_counter_mc, saturating and wrapping instances side by side.
module tb_click_counter_mc;

   localparam int NC  = 4;
   localparam int CW  = 2;
   localparam int DEB = 4;
`ifdef CLICK_SYNC_EN
   localparam int LAT  = DEB + 2;
   localparam bit SYNC = 1'b1;
`else
   localparam int LAT  = DEB;
   localparam bit SYNC = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NC-1:0] click = '0;
   logic [NC-1:0] clr = '0;
   logic [NC-1:0] y_s, ovf_s, y_w, ovf_w;
   logic [NC*CW-1:0] cnt_s, cnt_w;

   int n_cmp = 0;
   int n_bad = 0;
   logic [NC-1:0] yacc = '0;

   // soak model state
   logic [NC-1:0] lvl, ey, eo_s, eo_w, p0, p1, smpv;
   int            run [NC];
   logic [CW-1:0] ms [NC];
   logic [CW-1:0] mw [NC];

   always #5 clk = ~clk;

   click_counter_mc #(.N_CH(NC), .CNT_W(CW), .DEB_CYCLES(DEB), .WRAP(0)) u_sat (
      .clk(clk), .rst(rst), .click(click), .clr(clr), .y(y_s), .count(cnt_s), .ovf(ovf_s));

   click_counter_mc #(.N_CH(NC), .CNT_W(CW), .DEB_CYCLES(DEB), .WRAP(1)) u_wrap (
      .clk(clk), .rst(rst), .click(click), .clr(clr), .y(y_w), .count(cnt_w), .ovf(ovf_w));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         yacc = yacc | y_s;
      end
   endtask

   task automatic press(input logic [NC-1:0] mask);
      click = click | mask;
      tick(LAT + 1);
      click = click & ~mask;
      tick(LAT + 1);
   endtask

   initial begin
      #50000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // async reset and reset held with random inputs
      #2 rst = 1'b0;
      #1;
      chk("rst_y",   32'({y_s, y_w}), 0);
      chk("rst_cnt", 32'({cnt_s, cnt_w}), 0);
      chk("rst_ovf", 32'({ovf_s, ovf_w}), 0);
      for (int i = 0; i < 3; i++) begin
         click = NC'($urandom);
         clr   = NC'($urandom);
         tick(1);
         chk("rst_hold", 32'({y_s, y_w, cnt_s, cnt_w, ovf_s, ovf_w}), 0);
      end
      click = '0;
      clr   = '0;
      rst   = 1'b1;
      tick(2);

      // clean click on ch0
      click = 4'b0001;
      tick(LAT - 1);
      chk("t2_early_y", 32'(y_s), 0);
      tick(1);
      chk("t2_y_s",   32'(y_s), 1);
      chk("t2_y_w",   32'(y_w), 1);
      chk("t2_cnt_s", 32'(cnt_s), 8'h01);
      chk("t2_cnt_w", 32'(cnt_w), 8'h01);
      tick(1);
      chk("t2_y_onecyc", 32'(y_s), 0);
      yacc = '0;
      tick(8);
      chk("t2_hold_nopulse", 32'(yacc), 0);
      chk("t2_hold_cnt", 32'(cnt_s), 8'h01);
      click = '0;
      tick(LAT + 1);

      // short glitch on ch1, then bounce inside release debounce
      yacc  = '0;
      click = 4'b0010;
      tick(3);
      click = '0;
      tick(LAT + 2);
      chk("t3_glitch_y",   32'(yacc), 0);
      chk("t3_glitch_cnt", 32'(cnt_s), 8'h01);
      click = 4'b0010;
      tick(LAT);
      chk("t3_press_y",   32'(y_s), 4'b0010);
      chk("t3_press_cnt", 32'(cnt_s), 8'h05);
      yacc  = '0;
      click = 4'b0000; tick(1);
      click = 4'b0010; tick(1);
      click = 4'b0000; tick(1);
      click = 4'b0010; tick(LAT + 2);
      chk("t3_bounce_y",   32'(yacc), 0);
      chk("t3_bounce_cnt", 32'(cnt_s), 8'h05);
      click = '0;
      tick(LAT + 1);

      // saturate vs wrap on ch3 (CNT_W=2)
      press(4'b1000);
      press(4'b1000);
      press(4'b1000);
      chk("t4_cnt3_s", 32'(cnt_s[7:6]), 3);
      chk("t4_ovf3_s", 32'(ovf_s), 0);
      click = 4'b1000;
      tick(LAT);
      chk("t4_y4",      32'(y_s), 4'b1000);
      chk("t4_cnt4_s",  32'(cnt_s[7:6]), 3);
      chk("t4_ovf4_s",  32'(ovf_s), 4'b1000);
      chk("t4_cnt4_w",  32'(cnt_w[7:6]), 0);
      chk("t4_ovf4_w",  32'(ovf_w), 4'b1000);
      tick(1);
      chk("t4_ovf_w_pulse",  32'(ovf_w), 0);
      chk("t4_ovf_s_sticky", 32'(ovf_s), 4'b1000);
      click = '0;
      tick(LAT + 1);
      press(4'b1000);
      chk("t4_cnt5_s", 32'(cnt_s[7:6]), 3);
      chk("t4_ovf5_s", 32'(ovf_s), 4'b1000);
      chk("t4_cnt5_w", 32'(cnt_w[7:6]), 1);
      clr = 4'b1000;
      tick(1);
      clr = '0;
      chk("t4_clr_cnt_s", 32'(cnt_s), 8'h05);
      chk("t4_clr_cnt_w", 32'(cnt_w), 8'h05);
      chk("t4_clr_ovf_s", 32'(ovf_s), 0);

      // clr on the accept edge, then simultaneous accepts
      click = 4'b0100;
      tick(LAT - 1);
      clr = 4'b0100;
      tick(1);
      clr = '0;
      chk("t5_clr_acc_y",   32'(y_s), 4'b0100);
      chk("t5_clr_acc_cnt", 32'(cnt_s), 8'h05);
      chk("t5_clr_acc_yw",  32'(y_w), 4'b0100);
      click = '0;
      tick(LAT + 1);
      click = 4'b1111;
      tick(LAT);
      chk("t5_all_y",     32'(y_s), 4'b1111);
      chk("t5_all_cnt_s", 32'(cnt_s), 8'h5A);
      chk("t5_all_cnt_w", 32'(cnt_w), 8'h5A);
      click = '0;
      tick(LAT + 1);

      // reset in mid-debounce with click held through release
      click = 4'b0001;
      tick(2);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_cnt", 32'({cnt_s, cnt_w}), 0);
      chk("mid_rst_y",   32'({y_s, y_w}), 0);
      tick(2);
      rst = 1'b1;
      tick(LAT - 1);
      chk("mid_rst_early_y", 32'(y_s), 0);
      tick(1);
      chk("mid_rst_y_rel", 32'(y_s), 4'b0001);
      chk("mid_rst_cnt_rel", 32'(cnt_s), 8'h01);
      click = '0;
      tick(LAT + 1);

      // random soak against a run-length model
      rst = 1'b0;
      tick(1);
      lvl = '0; p0 = '0; p1 = '0; eo_s = '0; eo_w = '0;
      for (int b = 0; b < NC; b++) begin
         run[b] = 0; ms[b] = '0; mw[b] = '0;
      end
      rst = 1'b1;
      for (int c = 0; c < 1000; c++) begin
         for (int b = 0; b < NC; b++) begin
            if ($urandom_range(0, 3) == 0) click[b] = ~click[b];
            clr[b] = ($urandom_range(0, 63) == 0);
         end
         tick(1);
         if (SYNC) begin
            smpv = p1;
            p1   = p0;
            p0   = click;
         end else begin
            smpv = click;
         end
         for (int b = 0; b < NC; b++) begin
            ey[b] = 1'b0;
            if (smpv[b] != lvl[b]) begin
               run[b]++;
               if (run[b] == DEB) begin
                  lvl[b] = smpv[b];
                  run[b] = 0;
                  ey[b]  = smpv[b];
               end
            end else begin
               run[b] = 0;
            end
            if (clr[b]) begin
               ms[b] = '0; mw[b] = '0; eo_s[b] = 1'b0; eo_w[b] = 1'b0;
            end else begin
               eo_w[b] = 1'b0;
               if (ey[b]) begin
                  if (ms[b] == 2'd3) eo_s[b] = 1'b1;
                  else               ms[b] = ms[b] + 2'd1;
                  if (mw[b] == 2'd3) begin
                     mw[b]   = 2'd0;
                     eo_w[b] = 1'b1;
                  end else begin
                     mw[b] = mw[b] + 2'd1;
                  end
               end
            end
         end
         chk("soak_y_s",   32'(y_s), 32'(ey));
         chk("soak_y_w",   32'(y_w), 32'(ey));
         chk("soak_cnt_s", 32'(cnt_s), 32'({ms[3], ms[2], ms[1], ms[0]}));
         chk("soak_cnt_w", 32'(cnt_w), 32'({mw[3], mw[2], mw[1], mw[0]}));
         chk("soak_ovf_s", 32'(ovf_s), 32'(eo_s));
         chk("soak_ovf_w", 32'(ovf_w), 32'(eo_w));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
